// File: rtl/fusion_issue.sv
// Operand sequencer: splits an 8x8 (or 4x4) multiply into 4-bit passes for one fusion unit
// and accumulates the returned psums into a 16-bit product. One operation in flight at a time.
module fusion_issue #(
  parameter int FU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_in,
  input  logic [7:0]  op_weight,
  input  logic        op_wide,
  input  logic        op_s_in,
  input  logic        op_s_weight,
  output logic [3:0]  fu_in,
  output logic [3:0]  fu_weight,
  output logic [2:0]  fu_in_width,
  output logic [2:0]  fu_weight_width,
  output logic        fu_s_in,
  output logic        fu_s_weight,
  input  logic [7:0]  fu_psum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data
);

  localparam int DL = FU_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // shift is in units of 4 bits: 0, 1 or 2
  typedef struct packed {
    logic       vld;
    logic [1:0] shift;
    logic       sgn;
  } tag_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_op_ready;
  logic [7:0]  r_in;
  logic [7:0]  r_w;
  logic        r_wide;
  logic        r_s_in;
  logic        r_s_w;
  logic [1:0]  r_pass;
  logic [15:0] r_acc;
  logic [3:0]  r_fu_in;
  logic [3:0]  r_fu_w;
  logic        r_fu_s_in;
  logic        r_fu_s_w;
  tag_t        r_tag [DL];

  logic        w_accept;
  logic        w_issue;
  logic        w_last;
  logic [3:0]  w_nib_in;
  logic [3:0]  w_nib_w;
  logic        w_s_in;
  logic        w_s_w;
  logic [1:0]  w_shift;
  logic        w_cap;
  logic        w_inflight;
  logic [15:0] w_psum_ext;
  logic [15:0] w_addend;
  tag_t        w_tag_in;

  assign w_accept = (r_state == S_IDLE) && r_op_ready && op_valid;
  assign w_issue  = (r_state == S_ISSUE);
  assign w_last   = r_wide ? (r_pass == 2'd3) : 1'b1;

  // Pass order p0..p3: pass[1] picks the activation nibble, pass[0] the weight nibble
  assign w_nib_in = r_pass[1] ? r_in[7:4] : r_in[3:0];
  assign w_nib_w  = r_pass[0] ? r_w[7:4]  : r_w[3:0];
  assign w_s_in   = r_s_in & (r_wide ? r_pass[1] : 1'b1);
  assign w_s_w    = r_s_w  & (r_wide ? r_pass[0] : 1'b1);
  assign w_shift  = {1'b0, r_pass[0]} + {1'b0, r_pass[1]};

  assign w_tag_in = '{vld: w_issue, shift: w_shift, sgn: w_s_in | w_s_w};

  assign w_cap      = r_tag[DL-1].vld;
  assign w_psum_ext = r_tag[DL-1].sgn ? {{8{fu_psum[7]}}, fu_psum} : {8'h00, fu_psum};
  assign w_addend   = w_psum_ext << {r_tag[DL-1].shift, 2'b00};

  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < DL - 1; i++) begin
      w_inflight = w_inflight | r_tag[i].vld;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_cap && !w_inflight) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_ready <= 1'b0;
      r_in       <= 8'h00;
      r_w        <= 8'h00;
      r_wide     <= 1'b0;
      r_s_in     <= 1'b0;
      r_s_w      <= 1'b0;
      r_pass     <= 2'd0;
      r_acc      <= 16'h0000;
      r_fu_in    <= 4'h0;
      r_fu_w     <= 4'h0;
      r_fu_s_in  <= 1'b0;
      r_fu_s_w   <= 1'b0;
      for (int i = 0; i < DL; i++) r_tag[i] <= '0;
    end else begin
      r_state    <= w_next;
      r_op_ready <= (w_next == S_IDLE);

      if (w_accept) begin
        r_in   <= op_in;
        r_w    <= op_weight;
        r_wide <= op_wide;
        r_s_in <= op_s_in;
        r_s_w  <= op_s_weight;
        r_pass <= 2'd0;
      end else if (w_issue) begin
        r_pass <= r_pass + 2'd1;
      end

      if (w_accept) r_acc <= 16'h0000;
      else if (w_cap) r_acc <= r_acc + w_addend;

      if (w_issue) begin
        r_fu_in   <= w_nib_in;
        r_fu_w    <= w_nib_w;
        r_fu_s_in <= w_s_in;
        r_fu_s_w  <= w_s_w;
      end else begin
        r_fu_in   <= 4'h0;
        r_fu_w    <= 4'h0;
        r_fu_s_in <= 1'b0;
        r_fu_s_w  <= 1'b0;
      end

      r_tag[0] <= w_tag_in;
      for (int i = 1; i < DL; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign op_ready        = r_op_ready;
  assign fu_in           = r_fu_in;
  assign fu_weight       = r_fu_w;
  assign fu_in_width     = 3'b100;
  assign fu_weight_width = 3'b100;
  assign fu_s_in         = r_fu_s_in;
  assign fu_s_weight     = r_fu_s_w;
  assign res_valid       = (r_state == S_DONE);
  assign res_data        = r_acc;

endmodule
